mux8_rr_arbiter: RTL

Round-robin arbiter that shares one 8-to-1 data mux among eight requesters and forwards the winner's beats to a single valid/ready consumer. It owns the mux select. Each grant lasts until the requester's LAST beat, until the requester drops REQ, or until MAX_BEATS beats have transferred. The block sits between eight producer ports and one downstream sink, such as a shared bus or writeback port.

---
 rtl/mux8_rr_arbiter_if.sv | 36 +++
 rtl/mux8_rr_arbiter.sv | 122 ++++++++++++
 2 files changed

// File: rtl/mux8_rr_arbiter_if.sv
// Bundle of requester, grant and sink signals for mux8_rr_arbiter.
// Ports: REQ/LAST/D0..D7 from the eight producers, ACK/GNT/SEL back to them,
//        DOUT/OUT_VALID/OUT_LAST/OUT_READY handshake with the downstream sink.
interface mux8_rr_arbiter_if #(
  parameter int n = 32
);
  logic [7:0]   REQ;
  logic [7:0]   LAST;
  logic [n-1:0] D0;
  logic [n-1:0] D1;
  logic [n-1:0] D2;
  logic [n-1:0] D3;
  logic [n-1:0] D4;
  logic [n-1:0] D5;
  logic [n-1:0] D6;
  logic [n-1:0] D7;
  logic [7:0]   ACK;
  logic [7:0]   GNT;
  logic [2:0]   SEL;
  logic [n-1:0] DOUT;
  logic         OUT_VALID;
  logic         OUT_READY;
  logic         OUT_LAST;

  // master: producers plus sink (the environment around the arbiter)
  modport master (
    output REQ, LAST, D0, D1, D2, D3, D4, D5, D6, D7, OUT_READY,
    input  ACK, GNT, SEL, DOUT, OUT_VALID, OUT_LAST
  );

  // slave: the arbiter itself
  modport slave (
    input  REQ, LAST, D0, D1, D2, D3, D4, D5, D6, D7, OUT_READY,
    output ACK, GNT, SEL, DOUT, OUT_VALID, OUT_LAST
  );
endinterface

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter owning an 8:1 data mux; forwards the winner's beats to one sink.
// Latency: one arbitration cycle in IDLE before the first beat; beats then pass combinationally.
// Backpressure: OUT_READY=0 freezes state; the granted beat stays presented until accepted.
// Ports: CLK, RST (async active-high); bus.slave carries REQ/LAST/D0..D7 in,
//        ACK/GNT/SEL out, and DOUT/OUT_VALID/OUT_LAST/OUT_READY to the sink.
module mux8_rr_arbiter #(
  parameter int n         = 32,
  parameter int MAX_BEATS = 8
) (
  input logic              CLK,
  input logic              RST,
  mux8_rr_arbiter_if.slave bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] CNT_LIMIT = 8'(MAX_BEATS - 1);

  state_t     state_q, state_d;
  logic [2:0] sel_q, sel_d;
  logic [2:0] ptr_q, ptr_d;
  logic [7:0] cnt_q, cnt_d;

  // First requester at or after the priority pointer, wrapping mod 8.
  logic [2:0] winner;
  logic [2:0] idx;
  logic       found;

  always_comb begin
    winner = ptr_q;
    idx    = ptr_q;
    found  = 1'b0;
    for (int k = 0; k < 8; k++) begin
      idx = ptr_q + 3'(k);
      if (!found && bus.REQ[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  logic granted;
  logic out_valid;
  logic out_last;
  logic xfer;

  assign granted   = (state_q == GRANT);
  assign out_valid = granted && bus.REQ[sel_q];
  assign xfer      = out_valid && bus.OUT_READY;
  // Forced release on the MAX_BEATS-th beat even if the requester has more to send.
  assign out_last  = out_valid && (bus.LAST[sel_q] || (cnt_q == CNT_LIMIT));

  assign bus.GNT       = granted ? (8'b1 << sel_q) : 8'b0;
  assign bus.ACK       = xfer    ? (8'b1 << sel_q) : 8'b0;
  assign bus.SEL       = sel_q;
  assign bus.OUT_VALID = out_valid;
  assign bus.OUT_LAST  = out_last;

  logic [n-1:0] mux_dat;

  always_comb begin
    mux_dat = '0;
    case (sel_q)
      3'd0: mux_dat = bus.D0;
      3'd1: mux_dat = bus.D1;
      3'd2: mux_dat = bus.D2;
      3'd3: mux_dat = bus.D3;
      3'd4: mux_dat = bus.D4;
      3'd5: mux_dat = bus.D5;
      3'd6: mux_dat = bus.D6;
      3'd7: mux_dat = bus.D7;
      default: mux_dat = '0;
    endcase
  end

  assign bus.DOUT = out_valid ? mux_dat : '0;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          sel_d   = winner;
          cnt_d   = 8'd0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!bus.REQ[sel_q]) begin
          // Requester withdrew: release without a beat; it still loses priority.
          state_d = IDLE;
          ptr_d   = sel_q + 3'd1;
        end else if (xfer) begin
          cnt_d = cnt_q + 8'd1;
          if (out_last) begin
            state_d = IDLE;
            ptr_d   = sel_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      sel_q   <= 3'd0;
      ptr_q   <= 3'd0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
